// File: rtl/rc_add_sub_8bit.sv
`default_nettype none
// ============================================================================
// Module      : rc_add_sub_8bit
// Description : 8-bit ripple-carry adder/subtractor with registered sum,
//               unsigned carry/borrow and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module rc_add_sub_8bit (
    input  logic clk,
    input  logic rst_n,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic A5,
    input  logic A6,
    input  logic A7,
    input  logic B0,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    input  logic B4,
    input  logic B5,
    input  logic B6,
    input  logic B7,
    input  logic M,
    output logic S0,
    output logic S1,
    output logic S2,
    output logic S3,
    output logic S4,
    output logic S5,
    output logic S6,
    output logic S7,
    output logic Cout,
    output logic V
);

    localparam int c_WIDTH = 8;

    logic [c_WIDTH-1:0] w_a;
    logic [c_WIDTH-1:0] w_b;
    logic [c_WIDTH-1:0] w_b_x;
    logic [c_WIDTH:0]   w_carry;
    logic [c_WIDTH-1:0] w_sum_cell;

    logic [c_WIDTH-1:0] w_sum_d;
    logic               w_cout_d;
    logic               w_v_d;

    logic [c_WIDTH-1:0] r_sum_q;
    logic               r_cout_q;
    logic               r_v_q;

    assign w_a = {A7, A6, A5, A4, A3, A2, A1, A0};
    assign w_b = {B7, B6, B5, B4, B3, B2, B1, B0};

    // Mode doubles as carry-in so subtract becomes A + ~B + 1 on the same chain.
    assign w_carry[0] = M;

    generate
        for (genvar i = 0; i < c_WIDTH; i++) begin : g_bit
            assign w_b_x[i]       = w_b[i] ^ M;
            assign w_sum_cell[i]  = w_a[i] ^ w_b_x[i] ^ w_carry[i];
            assign w_carry[i+1]   = (w_a[i] & w_b_x[i]) | (w_carry[i] & (w_a[i] ^ w_b_x[i]));
        end
    endgenerate

    always_comb begin
        w_sum_d  = w_sum_cell;
        w_cout_d = w_carry[c_WIDTH];
        w_v_d    = w_carry[c_WIDTH-1] ^ w_carry[c_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_q  <= '0;
            r_cout_q <= 1'b0;
            r_v_q    <= 1'b0;
        end else begin
            r_sum_q  <= w_sum_d;
            r_cout_q <= w_cout_d;
            r_v_q    <= w_v_d;
        end
    end

    assign S0   = r_sum_q[0];
    assign S1   = r_sum_q[1];
    assign S2   = r_sum_q[2];
    assign S3   = r_sum_q[3];
    assign S4   = r_sum_q[4];
    assign S5   = r_sum_q[5];
    assign S6   = r_sum_q[6];
    assign S7   = r_sum_q[7];
    assign Cout = r_cout_q;
    assign V    = r_v_q;

endmodule
`default_nettype wire

// File: tb/tb_rc_add_sub_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc_add_sub_8bit
// Description : Directed self-checking bench for rc_add_sub_8bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc_add_sub_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    wire  [7:0] s;
    wire        cout;
    wire        v;

    int checks;
    int errors;

    rc_add_sub_8bit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
        .A4(a[4]), .A5(a[5]), .A6(a[6]), .A7(a[7]),
        .B0(b[0]), .B1(b[1]), .B2(b[2]), .B3(b[3]),
        .B4(b[4]), .B5(b[5]), .B6(b[6]), .B7(b[7]),
        .M (m),
        .S0(s[0]), .S1(s[1]), .S2(s[2]), .S3(s[3]),
        .S4(s[4]), .S5(s[5]), .S6(s[6]), .S7(s[7]),
        .Cout(cout),
        .V   (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, then sample 1 time unit after the capturing rising edge.
    task automatic drive_and_clock(input logic [7:0] ta, input logic [7:0] tb, input logic tm);
        @(negedge clk);
        a = ta;
        b = tb;
        m = tm;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        m = 1'($urandom);
        #1;
        checks++;
        if ({s, cout, v} !== 10'b0) begin
            errors++;
            $display("FAIL reset_immediate: got S=%02h C=%b V=%b, want 00 0 0", s, cout, v);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({s, cout, v} !== 10'b0) begin
                errors++;
                $display("FAIL reset_hold%0d: got S=%02h C=%b V=%b, want 00 0 0", k, s, cout, v);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [9:0] ve [3];
        va = '{8'h0F, 8'h55, 8'h12};
        vb = '{8'h07, 8'hAA, 8'h34};
        ve = '{{8'h16, 1'b0, 1'b0}, {8'hFF, 1'b0, 1'b0}, {8'h46, 1'b0, 1'b0}};
        for (int k = 0; k < 3; k++) begin
            drive_and_clock(va[k], vb[k], 1'b0);
            checks++;
            if ({s, cout, v} !== ve[k]) begin
                errors++;
                $display("FAIL add%0d: got {S,C,V}=%03h, want %03h", k, {s, cout, v}, ve[k]);
            end
        end
    endtask

    task automatic test_sub;
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [9:0] ve [3];
        va = '{8'h0F, 8'h80, 8'h00};
        vb = '{8'h07, 8'h01, 8'h01};
        ve = '{{8'h08, 1'b1, 1'b0}, {8'h7F, 1'b1, 1'b1}, {8'hFF, 1'b0, 1'b0}};
        for (int k = 0; k < 3; k++) begin
            drive_and_clock(va[k], vb[k], 1'b1);
            checks++;
            if ({s, cout, v} !== ve[k]) begin
                errors++;
                $display("FAIL sub%0d: got {S,C,V}=%03h, want %03h", k, {s, cout, v}, ve[k]);
            end
        end
    endtask

    task automatic test_overflow;
        drive_and_clock(8'h7F, 8'h01, 1'b0);
        checks++;
        if ({s, cout, v} !== {8'h80, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_add_pos: got S=%02h C=%b V=%b, want 80 0 1", s, cout, v);
        end
        drive_and_clock(8'hFF, 8'h01, 1'b0);
        checks++;
        if ({s, cout, v} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_add: got S=%02h C=%b V=%b, want 00 1 0", s, cout, v);
        end
        drive_and_clock(8'h80, 8'h80, 1'b0);
        checks++;
        if ({s, cout, v} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_add_neg: got S=%02h C=%b V=%b, want 00 1 1", s, cout, v);
        end
        drive_and_clock(8'h7F, 8'hFF, 1'b1);
        checks++;
        if ({s, cout, v} !== {8'h80, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_sub: got S=%02h C=%b V=%b, want 80 0 1", s, cout, v);
        end
    endtask

    task automatic test_mode_change;
        drive_and_clock(8'h0F, 8'h07, 1'b0);
        drive_and_clock(8'h0F, 8'h07, 1'b1);
        checks++;
        if ({s, cout, v} !== {8'h08, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mode_to_sub: got S=%02h C=%b V=%b, want 08 1 0", s, cout, v);
        end
        drive_and_clock(8'h0F, 8'h07, 1'b0);
        checks++;
        if ({s, cout, v} !== {8'h16, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mode_to_add: got S=%02h C=%b V=%b, want 16 0 0", s, cout, v);
        end
    endtask

    task automatic test_reset_mid;
        drive_and_clock(8'hFF, 8'hFF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s, cout, v} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid: got S=%02h C=%b V=%b, want 00 0 0", s, cout, v);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({s, cout, v} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: got S=%02h C=%b V=%b, want 00 0 0", s, cout, v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_and_clock(8'h00, 8'h01, 1'b1);
        checks++;
        if ({s, cout, v} !== {8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got S=%02h C=%b V=%b, want FF 0 0", s, cout, v);
        end
    endtask

    // One new vector every cycle against an arithmetic reference model.
    task automatic test_back_to_back;
        logic [7:0] tb_b;
        logic [7:0] es;
        logic       ec;
        logic       ev;
        logic [8:0] sum9;
        int         bad;
        bad = 0;
        for (int mm = 0; mm < 2; mm++) begin
            for (int aa = 0; aa < 256; aa++) begin
                for (int k = 0; k < 10; k++) begin
                    case (k)
                        0: tb_b = 8'h00;
                        1: tb_b = 8'h01;
                        2: tb_b = 8'h7F;
                        3: tb_b = 8'h80;
                        4: tb_b = 8'hFF;
                        5: tb_b = 8'(aa);
                        default: tb_b = 8'(aa * 13 + k * 71);
                    endcase
                    if (mm == 0) begin
                        sum9 = {1'b0, 8'(aa)} + {1'b0, tb_b};
                        es   = sum9[7:0];
                        ec   = sum9[8];
                        ev   = (aa[7] == tb_b[7]) && (es[7] != aa[7]);
                    end else begin
                        es   = 8'(aa) - tb_b;
                        ec   = (8'(aa) >= tb_b);
                        ev   = (aa[7] != tb_b[7]) && (es[7] != aa[7]);
                    end
                    drive_and_clock(8'(aa), tb_b, 1'(mm));
                    checks++;
                    if ({s, cout, v} !== {es, ec, ev}) begin
                        errors++;
                        if (bad < 10)
                            $display("FAIL sweep m=%0d a=%02h b=%02h: got S=%02h C=%b V=%b, want %02h %b %b",
                                     mm, aa[7:0], tb_b, s, cout, v, es, ec, ev);
                        bad++;
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        m      = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_mode_change();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
